// File: rtl/dsp_master_arbiter_if.sv
// Downstream Wishbone-master handshake bundle between the arbiter and the bus master.
// The arbiter drives the request side; the bus master returns active and read data.
interface dsp_master_arbiter_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic          start;
    logic [aw-1:0] address;
    logic [3:0]    selection;
    logic          write;
    logic [dw-1:0] data_wr;
    logic          active;
    logic [dw-1:0] data_rd;

    modport master (
        output start, address, selection, write, data_wr,
        input  active, data_rd
    );

    modport slave (
        input  start, address, selection, write, data_wr,
        output active, data_rd
    );
endinterface

// File: rtl/dsp_master_arbiter.sv
// Four-requester round-robin arbiter in front of a single Wishbone master,
// with a launch timeout on the active handshake and sticky overrun flags.
module dsp_master_arbiter #(
    parameter int dw             = 32,
    parameter int aw             = 32,
    parameter int LAUNCH_TIMEOUT = 8
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [3:0]           req_start_i,
    input  logic [4*aw-1:0]      req_address_i,
    input  logic [15:0]          req_selection_i,
    input  logic [3:0]           req_write_i,
    input  logic [4*dw-1:0]      req_data_wr_i,
    output logic [3:0]           req_busy_o,
    output logic [3:0]           req_done_o,
    output logic                 req_err_o,
    output logic [3:0]           req_overrun_o,
    output logic [dw-1:0]        req_data_rd_o,
    dsp_master_arbiter_if.master wb
);

    typedef enum logic [1:0] {IDLE, WAIT_ACTIVE, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        pending;
    logic [1:0]        ptr;
    logic [1:0]        gnt;
    logic [1:0]        winner;
    logic [7:0]        cnt;
    logic [3:0]        accept;
    logic              do_grant, do_timeout, do_finish;

    logic [3:0][aw-1:0] lat_addr;
    logic [3:0][3:0]    lat_sel;
    logic [3:0]         lat_we;
    logic [3:0][dw-1:0] lat_wd;

    always_comb begin
        req_busy_o = pending | ((state != IDLE) ? (4'b0001 << gnt) : 4'b0000);
        accept     = req_start_i & ~req_busy_o;
    end

    // Scan from the highest offset down so the nearest pending index after ptr wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (pending[ptr + 2'(k)]) winner = ptr + 2'(k);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_timeout = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    do_grant  = 1'b1;
                    state_nxt = WAIT_ACTIVE;
                end
            end
            WAIT_ACTIVE: begin
                if (wb.active) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == 8'(LAUNCH_TIMEOUT)) begin
                    do_timeout = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!wb.active) begin
                    do_finish = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            pending       <= '0;
            ptr           <= '0;
            gnt           <= '0;
            cnt           <= '0;
            lat_addr      <= '0;
            lat_sel       <= '0;
            lat_we        <= '0;
            lat_wd        <= '0;
            wb.start      <= 1'b0;
            wb.address    <= '0;
            wb.selection  <= '0;
            wb.write      <= 1'b0;
            wb.data_wr    <= '0;
            req_done_o    <= '0;
            req_err_o     <= 1'b0;
            req_overrun_o <= '0;
            req_data_rd_o <= '0;
        end else begin
            // A grant never targets a bit being accepted in the same cycle (it is busy).
            pending       <= (pending & ~(do_grant ? (4'b0001 << winner) : 4'b0000)) | accept;
            req_overrun_o <= req_overrun_o | (req_start_i & req_busy_o);

            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    lat_addr[i] <= req_address_i[i*aw +: aw];
                    lat_sel[i]  <= req_selection_i[i*4 +: 4];
                    lat_we[i]   <= req_write_i[i];
                    lat_wd[i]   <= req_data_wr_i[i*dw +: dw];
                end
            end

            wb.start <= do_grant;
            if (do_grant) begin
                gnt          <= winner;
                ptr          <= winner + 2'd1;
                wb.address   <= lat_addr[winner];
                wb.selection <= lat_sel[winner];
                wb.write     <= lat_we[winner];
                wb.data_wr   <= lat_wd[winner];
            end

            // Counter reads 1 during the start cycle.
            if (do_grant)                 cnt <= 8'd1;
            else if (state == WAIT_ACTIVE) cnt <= cnt + 8'd1;
            else                          cnt <= '0;

            req_done_o <= (do_timeout || do_finish) ? (4'b0001 << gnt) : 4'b0000;
            req_err_o  <= do_timeout;
            if (do_finish) req_data_rd_o <= wb.data_rd;
        end
    end

endmodule

// File: tb/tb_dsp_master_arbiter.sv
// Randomized bench for dsp_master_arbiter: a transaction-timing model predicts every
// output each cycle, and directed scenarios pin latency, ordering, timeout and reset.
module tb_dsp_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LT = 8;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic [3:0]      req_start_i;
    logic [4*AW-1:0] req_address_i;
    logic [15:0]     req_selection_i;
    logic [3:0]      req_write_i;
    logic [4*DW-1:0] req_data_wr_i;
    logic [3:0]      req_busy_o, req_done_o, req_overrun_o;
    logic            req_err_o;
    logic [DW-1:0]   req_data_rd_o;

    dsp_master_arbiter_if #(.dw(DW), .aw(AW)) wbif();

    dsp_master_arbiter #(.dw(DW), .aw(AW), .LAUNCH_TIMEOUT(LT)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .req_start_i(req_start_i), .req_address_i(req_address_i),
        .req_selection_i(req_selection_i), .req_write_i(req_write_i),
        .req_data_wr_i(req_data_wr_i), .req_busy_o(req_busy_o),
        .req_done_o(req_done_o), .req_err_o(req_err_o),
        .req_overrun_o(req_overrun_o), .req_data_rd_o(req_data_rd_o),
        .wb(wbif)
    );

    always #5 wb_clk = ~wb_clk;

    // stimulus for the next cycle
    logic [3:0]    s_start;
    bit            s_rst;
    logic [AW-1:0] s_addr [4];
    logic [3:0]    s_sel  [4];
    logic          s_we   [4];
    logic [DW-1:0] s_wd   [4];
    bit            f_use;
    int            f_d, f_L;
    logic [DW-1:0] f_rd;

    // reference model: pending requests plus the timing plan of the transfer in flight
    bit            m_valid;
    bit            m_pend [4];
    logic [AW-1:0] m_laddr [4];
    logic [3:0]    m_lsel  [4];
    logic          m_lwe   [4];
    logic [DW-1:0] m_lwd   [4];
    int            m_ptr, m_cur, m_s, m_d, m_L, m_done;
    bit            m_err;
    logic [DW-1:0] m_rd_plan, m_last_rd, m_wd;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_sel, m_ovr;
    logic          m_we;

    int cyc, n_chk, n_fail;
    int            ev_st_cyc [$];
    logic [AW-1:0] ev_st_addr [$];
    int            ev_dn_cyc [$];
    int            ev_dn_idx [$];
    bit            ev_dn_err [$];

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_ptr = 0; m_cur = -1; m_s = 0; m_d = 0; m_L = 0; m_done = 0; m_err = 0;
        m_addr = '0; m_sel = '0; m_we = 1'b0; m_wd = '0;
        m_ovr = '0; m_last_rd = '0; m_rd_plan = '0;
        m_valid = 1;
    endtask

    task automatic clear_ev();
        ev_st_cyc.delete(); ev_st_addr.delete();
        ev_dn_cyc.delete(); ev_dn_idx.delete(); ev_dn_err.delete();
    endtask

    task automatic tick();
        logic [3:0] e_busy, e_done;
        logic       e_start, e_err;
        bit         fall, idle;
        int         w, idx;
        @(negedge wb_clk);
        e_busy = '0;
        e_done = '0;
        for (int i = 0; i < 4; i++) begin
            e_busy[i] = m_pend[i] || (m_cur == i && cyc < m_done);
            e_done[i] = (m_cur == i && cyc == m_done);
        end
        e_start = (m_cur >= 0 && cyc == m_s);
        e_err   = (e_done != 4'b0) && m_err;
        if (m_valid) begin
            chk("busy", req_busy_o, e_busy);
            chk("done", req_done_o, e_done);
            chk("err", req_err_o, e_err);
            chk("overrun", req_overrun_o, m_ovr);
            chk("data_rd_o", req_data_rd_o, m_last_rd);
            chk("start", wbif.start, e_start);
            chk("address", wbif.address, m_addr);
            chk("selection", wbif.selection, m_sel);
            chk("write", wbif.write, m_we);
            chk("data_wr", wbif.data_wr, m_wd);
        end
        if (wbif.start === 1'b1) begin
            ev_st_cyc.push_back(cyc);
            ev_st_addr.push_back(wbif.address);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_done_o[i] === 1'b1) begin
                ev_dn_cyc.push_back(cyc);
                ev_dn_idx.push_back(i);
                ev_dn_err.push_back(req_err_o);
            end
        end
        // drive this cycle's inputs
        wb_rst      = s_rst;
        req_start_i = s_start;
        for (int i = 0; i < 4; i++) begin
            req_address_i[i*AW +: AW] = s_addr[i];
            req_selection_i[i*4 +: 4] = s_sel[i];
            req_write_i[i]            = s_we[i];
            req_data_wr_i[i*DW +: DW] = s_wd[i];
        end
        fall          = (m_cur >= 0) && !m_err && (cyc == m_s + m_d + m_L);
        wbif.active   = (m_cur >= 0) && !m_err && (cyc >= m_s + m_d) && (cyc < m_s + m_d + m_L);
        wbif.data_rd  = fall ? m_rd_plan : $urandom;
        // advance the model to the next cycle
        if (s_rst) begin
            model_reset();
        end else begin
            if (fall) m_last_rd = m_rd_plan;
            idle = (m_cur < 0) || (cyc >= m_done);
            w = -1;
            if (idle) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (w < 0 && m_pend[idx]) w = idx;
                end
            end
            if (w >= 0) begin
                m_pend[w] = 0;
                m_ptr  = (w + 1) % 4;
                m_cur  = w;
                m_s    = cyc + 1;
                m_addr = m_laddr[w]; m_sel = m_lsel[w]; m_we = m_lwe[w]; m_wd = m_lwd[w];
                if (f_use) begin
                    m_d = f_d; m_L = f_L; m_rd_plan = f_rd; f_use = 0;
                end else begin
                    m_d = $urandom_range(0, LT + 1); m_L = $urandom_range(1, 4); m_rd_plan = $urandom;
                end
                m_err  = (m_d >= LT);
                m_done = m_err ? m_s + LT : m_s + m_d + m_L + 1;
            end else if (idle) begin
                m_cur = -1;
            end
            for (int i = 0; i < 4; i++) begin
                if (s_start[i]) begin
                    if (e_busy[i]) m_ovr[i] = 1'b1;
                    else begin
                        m_pend[i] = 1;
                        m_laddr[i] = s_addr[i]; m_lsel[i] = s_sel[i];
                        m_lwe[i] = s_we[i]; m_lwd[i] = s_wd[i];
                    end
                end
            end
        end
        cyc++;
        s_start = '0;
        s_rst   = 0;
    endtask

    task automatic idle_ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        s_rst = 1; tick();
        s_rst = 1; tick();
        clear_ev();
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 4; i++) begin
            s_sel[i] = 4'($urandom); s_we[i] = 1'($urandom); s_wd[i] = $urandom;
        end
    endtask

    initial begin
        int c0;
        cyc = 0; n_chk = 0; n_fail = 0; m_valid = 0; f_use = 0;
        wb_rst = 1'b1; req_start_i = '0; req_address_i = '0; req_selection_i = '0;
        req_write_i = '0; req_data_wr_i = '0; wbif.active = 1'b0; wbif.data_rd = '0;
        s_start = '0; s_rst = 0;
        for (int i = 0; i < 4; i++) s_addr[i] = '0;
        rand_fields();
        model_reset();
        m_valid = 0;

        // reset state
        do_reset();
        tick();
        chk("rst_busy", req_busy_o, 4'h0);
        chk("rst_start", wbif.start, 1'b0);
        chk("rst_addr", wbif.address, 0);

        // all four at once from ptr=0, then 0 and 2 together
        for (int i = 0; i < 4; i++) s_addr[i] = AW'(32'h100 * (i + 1));
        s_start = 4'hF; tick();
        idle_ticks(4 * (LT + 8));
        s_start = 4'b0101; tick();
        idle_ticks(2 * (LT + 8));
        chk("rr_count", ev_st_addr.size(), 6);
        chk("rr_0", ev_st_addr[0], 'h100);
        chk("rr_1", ev_st_addr[1], 'h200);
        chk("rr_2", ev_st_addr[2], 'h300);
        chk("rr_3", ev_st_addr[3], 'h400);
        chk("rr_4", ev_st_addr[4], 'h100);
        chk("rr_5", ev_st_addr[5], 'h300);

        // single read latency
        do_reset();
        f_use = 1; f_d = 1; f_L = 4; f_rd = 32'hDEADBEEF;
        s_addr[0] = 32'h0000_0010; s_we[0] = 1'b0;
        c0 = cyc; s_start = 4'b0001; tick();
        idle_ticks(12);
        chk("rd_start_cnt", ev_st_cyc.size(), 1);
        chk("rd_start_cyc", ev_st_cyc[0] - c0, 2);
        chk("rd_start_addr", ev_st_addr[0], 'h10);
        chk("rd_done_cyc", ev_dn_cyc[0] - c0, 8);
        chk("rd_done_idx", ev_dn_idx[0], 0);
        chk("rd_done_err", ev_dn_err[0], 0);
        chk("rd_data", req_data_rd_o, 32'hDEADBEEF);

        // launch timeout, then the queued requester 3 launches right away
        do_reset();
        f_use = 1; f_d = LT + 1; f_L = 1; f_rd = '0;
        s_addr[0] = 32'h70; s_addr[3] = 32'h73;
        s_start = 4'b1001; tick();
        idle_ticks(2 * LT + 20);
        chk("to_err", ev_dn_err[0], 1);
        chk("to_idx", ev_dn_idx[0], 0);
        chk("to_lat", ev_dn_cyc[0] - ev_st_cyc[0], LT);
        chk("to_next_addr", ev_st_addr[1], 'h73);
        chk("to_next_cyc", ev_st_cyc[1] - ev_dn_cyc[0], 1);

        // overrun keeps the first address
        do_reset();
        f_use = 1; f_d = 2; f_L = 2; f_rd = 32'h1234;
        s_addr[1] = 32'h11; s_start = 4'b0010; tick();
        tick();
        s_addr[1] = 32'h44; s_start = 4'b0010; tick();
        idle_ticks(20);
        chk("ovr_flag", req_overrun_o, 4'b0010);
        chk("ovr_addr", ev_st_addr[0], 'h11);
        chk("ovr_cnt", ev_st_cyc.size(), 1);

        // restart in the done cycle is accepted
        do_reset();
        f_use = 1; f_d = 0; f_L = 1; f_rd = 32'h5;
        s_addr[2] = 32'h22; c0 = cyc; s_start = 4'b0100; tick();
        idle_ticks(3);
        s_addr[2] = 32'h23; s_start = 4'b0100; tick();
        idle_ticks(20);
        chk("rs_done_cyc", ev_dn_cyc[0] - c0, 4);
        chk("rs_ovr", req_overrun_o, 4'h0);
        chk("rs_addr", ev_st_addr[1], 'h23);
        chk("rs_start_cyc", ev_st_cyc[1] - c0, 6);

        // reset while waiting for active to fall
        do_reset();
        f_use = 1; f_d = 0; f_L = 6; f_rd = 32'h9;
        s_addr[0] = 32'h55; s_start = 4'b0001; tick();
        idle_ticks(3);
        s_rst = 1; tick();
        tick();
        chk("mr_busy", req_busy_o, 4'h0);
        chk("mr_addr", wbif.address, 0);
        chk("mr_nodone", ev_dn_cyc.size(), 0);
        s_addr[0] = 32'h66; s_start = 4'b0001; tick();
        idle_ticks(20);
        chk("mr_addr2", ev_st_addr[ev_st_addr.size() - 1], 'h66);
        chk("mr_done2", ev_dn_cyc.size(), 1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rand_fields();
            for (int i = 0; i < 4; i++) begin
                s_addr[i]  = $urandom;
                s_start[i] = ($urandom_range(0, 7) == 0);
            end
            s_rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
